id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the 16-bit ALU (Rs, Rt, 4-bit OPcode -> Rd).
//  Captures decoded operands, opcode and destination from ID under a valid/ready handshake.
//  Presents forwarded Rs/Rt operands to the ALU, with EX/MEM and MEM/WB bypass.
//  Supports stall (back-pressure) and flush (branch squash).
// PARAMETERS
//  DATA_W      16  operand/result width (matches ALU)
//  REG_AW      3   register-address width (8 architectural regs, R0 reads zero)
//  OP_W        4   ALU opcode width
//  IMM_W       8   immediate field width, zero-extended to DATA_W
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  in_valid       in   1       ID presents an instruction
//  in_ready       out  1       stage accepts this cycle
//  in_opcode      in   OP_W    ALU opcode
//  in_rs_addr     in   REG_AW  source-1 register address
//  in_rt_addr     in   REG_AW  source-2 register address
//  in_rd_addr     in   REG_AW  destination register address
//  in_rs_data     in   DATA_W  register-file read of Rs
//  in_rt_data     in   DATA_W  register-file read of Rt
//  in_imm         in   IMM_W   immediate
//  in_use_imm     in   1       1: Rt operand = zero-extended in_imm
//  in_reg_write   in   1       instruction writes Rd
//  flush          in   1       squash the held instruction and the incoming one
//  out_ready      in   1       EX/MEM accepts ALU result this cycle
//  out_valid      out  1       ALU operands valid
//  out_rs         out  DATA_W  forwarded operand to ALU Rs
//  out_rt         out  DATA_W  forwarded operand (or immediate) to ALU Rt
//  out_opcode     out  OP_W    to ALU OPcode
//  out_rd_addr    out  REG_AW  destination for EX/MEM
//  out_reg_write  out  1       write-enable for EX/MEM; forced 0 when !out_valid
//  out_illegal    out  1       out_valid && opcode > 4'b0100 (ALU would output 0)
//  exmem_wr/_rd/_data  in 1/REG_AW/DATA_W  EX/MEM bypass source
//  memwb_wr/_rd/_data  in 1/REG_AW/DATA_W  MEM/WB bypass source
//  stall_cnt      out  16      cycles with out_valid && !out_ready, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0; all stored fields=0; stall_cnt=0; outputs are 0.
//  - in_ready = !out_valid || out_ready (combinational); one-deep buffer, latency 1 cycle.
//  - Per edge, priority: flush -> out_valid<=0, nothing captured (flush beats a simultaneous load);
//    else in_valid&&in_ready -> capture all in_* fields, out_valid<=1;
//    else out_valid&&out_ready -> out_valid<=0; else hold.
//  - Forwarding (combinational on outputs): for src s with addr a != 0 and !(s==Rt && use_imm):
//    exmem_wr && exmem_rd==a -> exmem_data; else memwb_wr && memwb_rd==a -> memwb_data;
//    else stored value. a==0 -> 16'h0000 always, never forwarded.
//  - Hold refresh: while out_valid && !out_ready, each edge writes the forwarded value back into
//    the stored operand, so a bypass is not lost when its producer retires.
//  - Immediate: out_rt = {{(DATA_W-IMM_W){1'b0}}, imm} when use_imm; never forwarded.
//  - stall_cnt increments on each edge with out_valid && !out_ready; saturates, does not wrap.
//  - rst_n deasserted mid-transfer: instruction lost, no partial state survives.
// STRUCTURE
//  - pipe_pkg: OP_AND=0, OP_ADD=1, OP_SUB=2, OP_SLL=3, OP_SRL=4, OP_MAX_LEGAL=4,
//    width constants DATA_W/REG_AW/OP_W, R0 address constant.
//  - Sub-module fwd_mux (one instance per operand): addr, stored data, two bypass ports -> data.
//  - Top: handshake/flush control, field registers, refresh path, stall counter.
// TESTING
//  - Reset: rst_n=0 mid-run -> out_valid=0, out_rs=out_rt=0, stall_cnt=0 immediately.
//  - ADD R3=R1+R2, rs_data=5, rt_data=7, no bypass -> next cycle out_valid=1, out_rs=5, out_rt=7, op=1.
//  - Bypass: rs_addr=1, exmem_wr=1 rd=1 data=0x00AA, memwb_wr=1 rd=1 data=0x0055 -> out_rs=0x00AA;
//    rs_addr=0 with the same bypass -> out_rs=0.
//  - Stall: out_ready=0 for 3 cycles with memwb bypass valid only in cycle 1 -> out_rs keeps bypassed
//    value, in_ready=0, stall_cnt=3.
//  - Flush with in_valid=1 same cycle -> out_valid=0 next cycle, out_reg_write=0, nothing captured.
//  - Immediate SLL, use_imm=1, imm=0x03, rt_addr=2 with exmem rd=2 -> out_rt=0x0003; opcode=4'b0111 -> out_illegal=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ALU opcodes and the ID/EX register layout.
package pipe_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 8;
  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_SLL = 4'd3,
    OP_SRL = 4'd4
  } op_e;
  localparam logic [OP_W-1:0]   OP_MAX_LEGAL = 4'd4;
  localparam logic [REG_AW-1:0] R0 = '0;
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rt_a;
    logic [REG_AW-1:0] rd_a;
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
    logic [IMM_W-1:0]  imm;
    logic              use_imm;
    logic              reg_write;
  } idex_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the newest value of one source register; EX/MEM beats MEM/WB, R0 is always zero.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] q
);
  assign q = (addr == R0)                      ? '0         :
             (exmem_wr && exmem_rd == addr)    ? exmem_data :
             (memwb_wr && memwb_rd == addr)    ? memwb_data : data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: one-deep ID/EX register with handshake, flush, operand bypass and stall counter.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt,
  output logic [OP_W-1:0]   out_opcode,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write,
  output logic              out_illegal,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [15:0]       stall_cnt
);
  idex_t             r;
  logic              v;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  fwd_mux u_fwd_rs (
    .addr(r.rs_a), .data(r.rs_d),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .q(fwd_rs)
  );
  fwd_mux u_fwd_rt (
    .addr(r.rt_a), .data(r.rt_d),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .q(fwd_rt)
  );
  assign in_ready      = !v || out_ready;
  assign out_valid     = v;
  assign out_rs        = fwd_rs;
  assign out_rt        = r.use_imm ? {{(DATA_W-IMM_W){1'b0}}, r.imm} : fwd_rt;
  assign out_opcode    = r.op;
  assign out_rd_addr   = r.rd_a;
  assign out_reg_write = v && r.reg_write;
  assign out_illegal   = v && (r.op > OP_MAX_LEGAL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v         <= 1'b0;
      r         <= '0;
      stall_cnt <= '0;
    end else begin
      if (v && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush) v <= 1'b0;
      else if (in_valid && in_ready) begin
        v <= 1'b1;
        r <= '{op: in_opcode, rs_a: in_rs_addr, rt_a: in_rt_addr, rd_a: in_rd_addr,
               rs_d: in_rs_data, rt_d: in_rt_data, imm: in_imm,
               use_imm: in_use_imm, reg_write: in_reg_write};
      end else if (v && out_ready) v <= 1'b0;
      else if (v) begin
        // stalled: latch the bypassed value so it survives its producer retiring
        r.rs_d <= fwd_rs;
        r.rt_d <= fwd_rt;
      end
    end
endmodule
